hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum data-memory wait cycles before abort.
REQ-002 Parameter PERF_W, default 32: width of each performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rs1_d, rs2_d  in  5 each  source registers of the instruction in Decode.
REQ-006 rs1_e, rs2_e, rd_e  in  5 each  source and destination registers in Execute.
REQ-007 load_e  in  1  the instruction in Execute is a load.
REQ-008 rd_m, reg_write_m  in  5/1  Memory-stage destination and write enable.
REQ-009 rd_w, reg_write_w  in  5/1  Writeback-stage destination and write enable.
REQ-010 pc_src_e  in  1  taken branch or jump resolved in Execute.
REQ-011 dmem_req_m, dmem_ready  in  1 each  Memory-stage access request and memory completion.
REQ-012 forward_a_e, forward_b_e  out  2 each  select lines for the 4:1 operand muxes.
REQ-013 stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC or pipeline register.
REQ-014 flush_d, flush_e  out  1 each  clear the D or E pipeline register to a bubble.
REQ-015 mem_err  out  1  one-cycle pulse on memory timeout.
REQ-016 stall_cycles, flush_count  out  PERF_W each  performance counters.

Function
REQ-017 Forward select encoding: 00 = register file, 01 = Writeback result, 10 = Memory-stage ALU result; 11 is never driven.
REQ-018 forward_a_e is 10 when reg_write_m, rd_m != 0 and rd_m == rs1_e; else 01 when reg_write_w, rd_w != 0 and rd_w == rs1_e; else 00. Memory stage has priority. forward_b_e follows the same rule using rs2_e.
REQ-019 Forward selects are combinational, with zero latency, in every state.
REQ-020 FSM states: RUN and MEM_WAIT. Reset state is RUN.
REQ-021 RUN -> MEM_WAIT when dmem_req_m && !dmem_ready; otherwise stay in RUN.
REQ-022 MEM_WAIT -> RUN when dmem_ready is high, or when the wait counter reaches TIMEOUT-1.
REQ-023 In RUN, lw_stall = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d). lw_stall drives stall_f, stall_d and flush_e, which inserts exactly one bubble.
REQ-024 In RUN, flush_d = pc_src_e, and flush_e = pc_src_e || lw_stall.
REQ-025 In MEM_WAIT, and in the RUN cycle that enters it, stall_f/d/e/m are all 1 and flush_d/flush_e are 0.
REQ-026 A branch pending in Execute during a freeze is flushed in the first cycle after the freeze ends.
REQ-027 stall_e and stall_m are 1 only during the memory freeze.
REQ-028 The wait counter clears on entry to MEM_WAIT and increments once per MEM_WAIT cycle.
REQ-029 On timeout, mem_err pulses for exactly one cycle and the FSM returns to RUN.
REQ-030 dmem_ready and timeout occurring in the same cycle count as success: no mem_err.

Reset
REQ-031 While reset is high: state is RUN, the wait counter is 0, and mem_err, stall_cycles and flush_count are 0.
REQ-032 Reset asserted during MEM_WAIT takes effect at the next edge; no mem_err pulse is generated.
REQ-033 Combinational stall and flush outputs are still evaluated from inputs during reset.

Configuration
REQ-034 Macro HAZARD_CTRL_PERF_EN defined: stall_cycles increments on every cycle with stall_f = 1, and flush_count increments on every cycle with flush_d || flush_e. Both counters wrap at 2^PERF_W.
REQ-035 Macro not defined: both counter ports exist and are tied to 0, and no counter registers are generated.

Structure
REQ-036 A shared package holds the forward-select enum (FWD_RF, FWD_WB, FWD_MEM), the FSM state enum, and the register-index width constant 5.
REQ-037 One sub-module, fwd_sel, computes one forward select and is instantiated twice (operands A and B).

Verification
REQ-038 rs1_e = 5, rd_m = 5, reg_write_m = 1, rd_w = 5, reg_write_w = 1 -> forward_a_e = 10; then reg_write_m = 0 -> forward_a_e = 01.
REQ-039 rd_m = 0, reg_write_m = 1, rs2_e = 0 -> forward_b_e = 00.
REQ-040 load_e = 1, rd_e = 7, rs2_d = 7 -> stall_f = stall_d = flush_e = 1 for one cycle; stall_e = 0.
REQ-041 dmem_req_m = 1 with dmem_ready low for 3 cycles, then high -> all stalls high for 4 cycles, then RUN; mem_err stays 0.
REQ-042 TIMEOUT = 16 and dmem_ready never rises -> mem_err is high on exactly the 16th wait cycle, then state is RUN.
REQ-043 With HAZARD_CTRL_PERF_EN, pc_src_e pulse plus one load-use stall -> flush_count = 2 and stall_cycles = 1; without the macro, both read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   // A producer matches a consumer only when it names the same non-zero register.
   function automatic logic reg_match(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
      return (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one Execute-stage source operand; Memory stage wins over Writeback.
module fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs_e_i,
   input  logic [REG_W-1:0] rd_m_i,
   input  logic             reg_write_m_i,
   input  logic [REG_W-1:0] rd_w_i,
   input  logic             reg_write_w_i,
   output fwd_sel_e         sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (reg_write_m_i && reg_match(rd_m_i, rs_e_i)) begin
         sel_o = FWD_MEM;
      end else if (reg_write_w_i && reg_match(rd_w_i, rs_e_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: forwarding, load-use stall, branch flush, memory freeze.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned PERF_W  = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  rs1_d,
   input  logic [REG_W-1:0]  rs2_d,
   input  logic [REG_W-1:0]  rs1_e,
   input  logic [REG_W-1:0]  rs2_e,
   input  logic [REG_W-1:0]  rd_e,
   input  logic              load_e,
   input  logic [REG_W-1:0]  rd_m,
   input  logic              reg_write_m,
   input  logic [REG_W-1:0]  rd_w,
   input  logic              reg_write_w,
   input  logic              pc_src_e,
   input  logic              dmem_req_m,
   input  logic              dmem_ready,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic              mem_err,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_count
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_enter;
   logic             timeout;
   logic             lw_stall;
   fwd_sel_e         fwd_a, fwd_b;

   fwd_sel u_fwd_a (
      .rs_e_i        (rs1_e),
      .rd_m_i        (rd_m),
      .reg_write_m_i (reg_write_m),
      .rd_w_i        (rd_w),
      .reg_write_w_i (reg_write_w),
      .sel_o         (fwd_a)
   );

   fwd_sel u_fwd_b (
      .rs_e_i        (rs2_e),
      .rd_m_i        (rd_m),
      .reg_write_m_i (reg_write_m),
      .rd_w_i        (rd_w),
      .reg_write_w_i (reg_write_w),
      .sel_o         (fwd_b)
   );

   assign forward_a_e = fwd_a;
   assign forward_b_e = fwd_b;

   assign mem_enter = dmem_req_m && !dmem_ready;
   assign timeout   = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
   assign lw_stall  = load_e && (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            if (mem_enter) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            if (dmem_ready || timeout) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // A branch held in Execute through a freeze keeps pc_src_e high and flushes once RUN resumes.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      mem_err = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_enter) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
            end else begin
               stall_f = lw_stall;
               stall_d = lw_stall;
               flush_d = pc_src_e;
               flush_e = pc_src_e || lw_stall;
            end
         end
         MEM_WAIT: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            mem_err = timeout && !dmem_ready && !reset;
         end
         default: ;
      endcase
   end

`ifdef HAZARD_CTRL_PERF_EN
   logic [PERF_W-1:0] stall_cycles_q, flush_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (stall_f) begin
            stall_cycles_q <= stall_cycles_q + PERF_W'(1);
         end
         if (flush_d || flush_e) begin
            flush_count_q <= flush_count_q + PERF_W'(1);
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expected outputs, monitor checks at negedge.
module tb_hazard_ctrl;

   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned PERF_W  = 32;
`ifdef HAZARD_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err}
   localparam logic [6:0] HZ_NONE = 7'b0000000;
   localparam logic [6:0] HZ_LW   = 7'b1100010;
   localparam logic [6:0] HZ_BR   = 7'b0000110;
   localparam logic [6:0] HZ_FRZ  = 7'b1111000;
   localparam logic [6:0] HZ_ERR  = 7'b1111001;

   logic              clk;
   logic              reset;
   logic [4:0]        rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic              load_e, reg_write_m, reg_write_w, pc_src_e, dmem_req_m, dmem_ready;
   logic [1:0]        forward_a_e, forward_b_e;
   logic              stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
   logic [PERF_W-1:0] stall_cycles, flush_count;

   hazard_ctrl #(.TIMEOUT(TIMEOUT), .PERF_W(PERF_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .rs1_d        (rs1_d),
      .rs2_d        (rs2_d),
      .rs1_e        (rs1_e),
      .rs2_e        (rs2_e),
      .rd_e         (rd_e),
      .load_e       (load_e),
      .rd_m         (rd_m),
      .reg_write_m  (reg_write_m),
      .rd_w         (rd_w),
      .reg_write_w  (reg_write_w),
      .pc_src_e     (pc_src_e),
      .dmem_req_m   (dmem_req_m),
      .dmem_ready   (dmem_ready),
      .forward_a_e  (forward_a_e),
      .forward_b_e  (forward_b_e),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .stall_e      (stall_e),
      .stall_m      (stall_m),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .mem_err      (mem_err),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]        fa;
      logic [1:0]        fb;
      logic [6:0]        hz;
      logic              chk_perf;
      logic [PERF_W-1:0] sc;
      logic [PERF_W-1:0] fc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   exp_t       mon_e;
   string      mon_nm;
   logic [6:0] mon_hz;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
      rd_m = '0; rd_w = '0; load_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
      pc_src_e = 1'b0; dmem_req_m = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic push_exp(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [6:0] hz, input logic chk, input int unsigned sc,
                           input int unsigned fc);
      exp_t e;
      e.fa = fa; e.fb = fb; e.hz = hz; e.chk_perf = chk;
      e.sc = PERF_W'(sc); e.fc = PERF_W'(fc);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: one expectation is consumed per cycle in which the driver posted one.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            mon_hz = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err};
            checks++;
            if ({forward_a_e, forward_b_e, mon_hz} !== {mon_e.fa, mon_e.fb, mon_e.hz}) begin
               errors++;
               $display("FAIL %s: got fa=%b fb=%b hz=%b, want fa=%b fb=%b hz=%b",
                        mon_nm, forward_a_e, forward_b_e, mon_hz, mon_e.fa, mon_e.fb, mon_e.hz);
            end
            if (mon_e.chk_perf) begin
               checks++;
               if (stall_cycles !== mon_e.sc || flush_count !== mon_e.fc) begin
                  errors++;
                  $display("FAIL %s_perf: got stall_cycles=%0d flush_count=%0d, want %0d %0d",
                           mon_nm, stall_cycles, flush_count, mon_e.sc, mon_e.fc);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      clr_in();
      tick();
      push_exp("reset_idle", 2'b00, 2'b00, HZ_NONE, 1'b1, 0, 0);
      tick();
      load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
      push_exp("reset_comb", 2'b00, 2'b00, HZ_LW, 1'b1, 0, 0);
      tick();
      reset = 1'b0; clr_in();
      push_exp("idle", 2'b00, 2'b00, HZ_NONE, 1'b1, 0, 0);

      // Forwarding
      tick(); clr_in();
      rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
      push_exp("fwd_mem_prio", 2'b10, 2'b00, HZ_NONE, 1'b0, 0, 0);
      tick(); reg_write_m = 1'b0;
      push_exp("fwd_wb", 2'b01, 2'b00, HZ_NONE, 1'b0, 0, 0);
      tick(); clr_in();
      rs1_e = 5'd3; rs2_e = 5'd3; rd_m = 5'd3; reg_write_m = 1'b1;
      push_exp("fwd_both_mem", 2'b10, 2'b10, HZ_NONE, 1'b0, 0, 0);
      tick(); clr_in();
      rs1_e = 5'd4; rs2_e = 5'd3; rd_m = 5'd4; reg_write_m = 1'b1; rd_w = 5'd3; reg_write_w = 1'b1;
      push_exp("fwd_split", 2'b10, 2'b01, HZ_NONE, 1'b0, 0, 0);
      tick(); clr_in();
      rs1_e = 5'd6; rd_w = 5'd6;
      push_exp("fwd_wb_nowrite", 2'b00, 2'b00, HZ_NONE, 1'b0, 0, 0);
      tick(); clr_in();
      rd_m = 5'd0; reg_write_m = 1'b1; rd_w = 5'd0; reg_write_w = 1'b1;
      push_exp("fwd_x0", 2'b00, 2'b00, HZ_NONE, 1'b0, 0, 0);

      // Load-use and branch
      tick(); clr_in();
      load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
      push_exp("lw_stall", 2'b00, 2'b00, HZ_LW, 1'b0, 0, 0);
      tick(); clr_in();
      push_exp("lw_clear", 2'b00, 2'b00, HZ_NONE, 1'b0, 0, 0);
      tick(); clr_in();
      load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
      push_exp("lw_x0", 2'b00, 2'b00, HZ_NONE, 1'b0, 0, 0);
      tick(); clr_in();
      rd_e = 5'd7; rs1_d = 5'd7;
      push_exp("lw_nonload", 2'b00, 2'b00, HZ_NONE, 1'b0, 0, 0);
      tick(); clr_in();
      pc_src_e = 1'b1;
      push_exp("branch", 2'b00, 2'b00, HZ_BR, 1'b0, 0, 0);
      tick(); clr_in();
      push_exp("perf_a", 2'b00, 2'b00, HZ_NONE, 1'b1, PERF ? 1 : 0, PERF ? 2 : 0);

      // Memory freeze with a branch held in Execute
      tick(); clr_in();
      dmem_req_m = 1'b1; pc_src_e = 1'b1;
      push_exp("mem_entry", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         push_exp("mem_wait", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      end
      tick(); dmem_ready = 1'b1;
      push_exp("mem_ack", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      tick(); clr_in(); pc_src_e = 1'b1;
      push_exp("post_freeze_branch", 2'b00, 2'b00, HZ_BR, 1'b0, 0, 0);
      tick(); clr_in();
      push_exp("perf_b", 2'b00, 2'b00, HZ_NONE, 1'b1, PERF ? 5 : 0, PERF ? 3 : 0);

      // Timeout
      tick(); clr_in(); dmem_req_m = 1'b1;
      push_exp("to_entry", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         tick();
         push_exp("to_wait", 2'b00, 2'b00, (i == 15) ? HZ_ERR : HZ_FRZ, 1'b0, 0, 0);
      end
      tick(); clr_in();
      push_exp("to_run", 2'b00, 2'b00, HZ_NONE, 1'b1, PERF ? 22 : 0, PERF ? 3 : 0);

      // Ready on the timeout cycle counts as success
      tick(); clr_in(); dmem_req_m = 1'b1;
      push_exp("tr_entry", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         tick();
         dmem_ready = (i == 15);
         push_exp("tr_wait", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      end
      tick(); clr_in();
      push_exp("tr_run", 2'b00, 2'b00, HZ_NONE, 1'b1, PERF ? 39 : 0, PERF ? 3 : 0);

      // Reset landing on the timeout cycle suppresses mem_err
      tick(); clr_in(); dmem_req_m = 1'b1;
      push_exp("rw_entry", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         tick();
         push_exp("rw_wait", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      end
      tick(); reset = 1'b1;
      push_exp("rst_in_wait", 2'b00, 2'b00, HZ_FRZ, 1'b0, 0, 0);
      tick(); reset = 1'b0; clr_in();
      push_exp("post_rst", 2'b00, 2'b00, HZ_NONE, 1'b1, 0, 0);
      tick(); clr_in(); dmem_req_m = 1'b1; dmem_ready = 1'b1;
      push_exp("req_ready_run", 2'b00, 2'b00, HZ_NONE, 1'b0, 0, 0);

      tick(); clr_in();
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
